// File: rtl/z4ml_serial_add_ctrl_if.sv
// Request/result bundle between the requesting logic and the serial add controller.
// The master drives the operation; the slave returns the handshake and result.
interface z4ml_serial_add_ctrl_if #(
    parameter int unsigned NDIG = 4
);
    localparam int unsigned W = 3 * NDIG;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;

    modport master (
        output start, sub, cin, op_a, op_b,
        input  busy, done, sum, cout, zero
    );

    modport slave (
        input  start, sub, cin, op_a, op_b,
        output busy, done, sum, cout, zero
    );
endinterface

// File: rtl/z4ml_serial_add_ctrl.sv
// Digit-serial multi-precision add/subtract sequencer around an external 3-bit adder slice.
// One 3-bit digit per cycle, LSB first, carry chained through a register.
module z4ml_serial_add_ctrl #(
    parameter int unsigned NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    z4ml_serial_add_ctrl_if.slave   req,
    output logic [2:0]              add_a,
    output logic [2:0]              add_b,
    output logic                    add_cin,
    input  logic [2:0]              add_sum,
    input  logic                    add_cout
);
    localparam int unsigned W    = 3 * NDIG;
    localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NDIG - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            zero_q, zero_d;
    logic [31:0]     dig_sh;
    logic            run;

    assign run    = (state_q == StRun);
    assign dig_sh = 32'(idx_q) * 32'd3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        zero_d  = zero_q;

        unique case (state_q)
            StIdle, StDone: begin
                // Result registers are left alone here so they hold until the first RUN write.
                if (req.start) begin
                    a_d     = req.op_a;
                    b_d     = req.sub ? ~req.op_b : req.op_b;
                    carry_d = req.sub ? 1'b1 : req.cin;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[dig_sh +: 3] = add_sum;
                carry_d            = add_cout;
                if (idx_q == IdxLast) begin
                    cout_d  = add_cout;
                    zero_d  = (sum_d == '0);
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Slice inputs come straight from registers and are quiet outside RUN.
    assign add_a   = run ? a_q[dig_sh +: 3] : 3'b000;
    assign add_b   = run ? b_q[dig_sh +: 3] : 3'b000;
    assign add_cin = run ? carry_q : 1'b0;

    assign req.busy = run;
    assign req.done = (state_q == StDone);
    assign req.sum  = sum_q;
    assign req.cout = cout_q;
    assign req.zero = zero_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (idx_q <= IdxLast)
            else $error("digit index out of range");
            assert (!(req.busy && req.done))
            else $error("busy and done overlap");
        end
    end
endmodule
